// File: rtl/sdram_cmd_sched.sv
// SDRAM command scheduler: arbitrates video refill against cache write-back/fill,
// issues one command per burst, counts beats and steers read data.
module sdram_cmd_sched #(
  parameter logic [14:0] VID_BASE   = 15'h6FF8,
  parameter logic [11:0] VID_LAST   = 12'd3071,
  parameter int          VID_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_need,
  input  logic        frame_sync,
  input  logic        cache_wr_req,
  input  logic        cache_rd_req,
  input  logic [11:0] cache_waddr,
  input  logic [11:0] cache_raddr,
  output logic [1:0]  sys_cmd,
  output logic [17:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_fill_en,
  output logic        cache_drain_en,
  output logic        cache_done,
  output logic [31:0] vq_data,
  output logic        vq_wr,
  output logic [11:0] vid_idx,
  output logic        busy
);

  // state | meaning
  // IDLE  | arbitrate, apply pending frame resync
  // ISSUE | command held on sys_cmd/sys_addr until acknowledged
  // BURST | counting data beats of the owner's burst
  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;
  // Owner codes equal the command issued for that owner.
  typedef enum logic [1:0] {OWN_CWR = 2'b01, OWN_VID = 2'b10, OWN_CRD = 2'b11} owner_t;

  localparam int SW = $clog2(VID_STREAK + 1);

  state_t        state, state_nxt;
  owner_t        owner, grant_owner;
  logic          grant;
  logic          streak_full;
  logic [SW-1:0] streak;
  logic [1:0]    ack_q;
  logic          ack_ok;
  logic          beat;
  logic          final_beat;
  logic [6:0]    beat_cnt;
  logic          sync_pend;
  logic [15:0]   low_half;
  logic [11:0]   eff_idx;
  logic [14:0]   vid_word;
  logic [17:0]   addr_sel;

  always_comb begin
    streak_full = (streak == SW'(VID_STREAK));
    grant       = 1'b0;
    grant_owner = OWN_VID;
    if (vid_need && !((cache_wr_req || cache_rd_req) && streak_full)) begin
      grant       = 1'b1;
      grant_owner = OWN_VID;
    end else if (cache_wr_req) begin
      grant       = 1'b1;
      grant_owner = OWN_CWR;
    end else if (cache_rd_req) begin
      grant       = 1'b1;
      grant_owner = OWN_CRD;
    end
  end

  // A resync still pending at grant time means this burst already starts at index 0.
  always_comb begin
    eff_idx  = sync_pend ? 12'd0 : vid_idx;
    vid_word = VID_BASE + {3'b000, ~eff_idx[11:2], eff_idx[1:0]};
    case (grant_owner)
      OWN_VID: addr_sel = {vid_word, 3'b000};
      OWN_CWR: addr_sel = {cache_waddr, 6'b0};
      default: addr_sel = {cache_raddr, 6'b0};
    endcase
  end

  assign ack_ok     = (state == ISSUE) && (sys_cmd_ack == sys_cmd) && (ack_q == 2'b00);
  assign beat       = (state == BURST) &&
                      ((owner == OWN_CWR) ? sys_wr_data_valid : sys_rd_data_valid);
  assign final_beat = beat && (beat_cnt == 7'd0);

  assign cache_fill_en  = (state == BURST) && (owner == OWN_CRD) && sys_rd_data_valid;
  assign cache_drain_en = (state == BURST) && (owner == OWN_CWR) && sys_wr_data_valid;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)      state_nxt = ISSUE;
      ISSUE:   if (ack_ok)     state_nxt = BURST;
      BURST:   if (final_beat) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_VID;
      sys_cmd    <= 2'b00;
      sys_addr   <= 18'd0;
      ack_q      <= 2'b00;
      beat_cnt   <= 7'd0;
      low_half   <= 16'd0;
      vq_data    <= 32'd0;
      vq_wr      <= 1'b0;
      cache_done <= 1'b0;
      streak     <= '0;
    end else begin
      ack_q      <= sys_cmd_ack;
      vq_wr      <= 1'b0;
      cache_done <= 1'b0;
      if (state == IDLE && grant) begin
        owner    <= grant_owner;
        sys_cmd  <= grant_owner;
        sys_addr <= addr_sel;
      end
      if (ack_ok) begin
        sys_cmd  <= 2'b00;
        sys_addr <= 18'd0;
        beat_cnt <= (owner == OWN_VID) ? 7'd15 : 7'd127;
      end
      // Beats count down from 15, so odd beats land on even counter values.
      if (beat) begin
        beat_cnt <= beat_cnt - 7'd1;
        if (owner == OWN_VID) begin
          if (!beat_cnt[0]) begin
            vq_data <= {sys_dout, low_half};
            vq_wr   <= 1'b1;
          end else begin
            low_half <= sys_dout;
          end
        end
      end
      if (final_beat) begin
        if (owner == OWN_VID) begin
          if (!streak_full) streak <= streak + SW'(1);
        end else begin
          cache_done <= 1'b1;
          streak     <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_idx   <= 12'd0;
      sync_pend <= 1'b0;
    end else if (state == IDLE && sync_pend) begin
      vid_idx   <= 12'd0;
      sync_pend <= frame_sync;
    end else if (final_beat && owner == OWN_VID) begin
      if (sync_pend || frame_sync) begin
        vid_idx   <= 12'd0;
        sync_pend <= 1'b0;
      end else begin
        vid_idx <= (vid_idx == VID_LAST) ? 12'd0 : vid_idx + 12'd1;
      end
    end else if (frame_sync) begin
      sync_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Directed bench for sdram_cmd_sched: arbitration, addressing, beat steering,
// index wrap/resync, reset mid-burst and held acknowledge.
module tb_sdram_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_need, frame_sync, cache_wr_req, cache_rd_req;
  logic [11:0] cache_waddr, cache_raddr;
  logic [1:0]  sys_cmd;
  logic [17:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid, sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic        cache_fill_en, cache_drain_en, cache_done;
  logic [31:0] vq_data;
  logic        vq_wr;
  logic [11:0] vid_idx;
  logic        busy;

  int total = 0;
  int bad   = 0;

  sdram_cmd_sched dut (
    .clk(clk), .rst(rst), .vid_need(vid_need), .frame_sync(frame_sync),
    .cache_wr_req(cache_wr_req), .cache_rd_req(cache_rd_req),
    .cache_waddr(cache_waddr), .cache_raddr(cache_raddr),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout(sys_dout), .cache_fill_en(cache_fill_en), .cache_drain_en(cache_drain_en),
    .cache_done(cache_done), .vq_data(vq_data), .vq_wr(vq_wr),
    .vid_idx(vid_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(output logic [1:0] cmd, output logic [17:0] addr);
    int n = 0;
    while (sys_cmd == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_seen", 32'(sys_cmd != 2'b00), 32'd1);
    cmd  = sys_cmd;
    addr = sys_addr;
  endtask

  // Acks cmd (held ack_len cycles), then drives the full burst; counts the
  // owner's enable (fill/drain) or vq_wr pulses.
  task automatic burst(input logic [1:0] cmd, input int ack_len, input int sync_at,
                       output int cnt, output logic done);
    int n;
    sys_cmd_ack = cmd;
    repeat (ack_len) tick();
    sys_cmd_ack = 2'b00;
    n   = (cmd == 2'b10) ? 16 : 128;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (cmd == 2'b01) sys_wr_data_valid = 1'b1;
      else              sys_rd_data_valid = 1'b1;
      sys_dout   = 16'(i);
      frame_sync = (i == sync_at);
      #1;
      if (cmd == 2'b11 && cache_fill_en)  cnt++;
      if (cmd == 2'b01 && cache_drain_en) cnt++;
      tick();
      if (cmd == 2'b10 && vq_wr) cnt++;
    end
    sys_rd_data_valid = 1'b0;
    sys_wr_data_valid = 1'b0;
    frame_sync        = 1'b0;
    done = cache_done;
  endtask

  task automatic serve(output logic [1:0] cmd, output logic [17:0] addr,
                       output int cnt, output logic done);
    wait_cmd(cmd, addr);
    burst(cmd, 1, -1, cnt, done);
  endtask

  initial begin
    logic [1:0]  cmd;
    logic [17:0] addr;
    int          cnt, vq_cnt;
    logic        done;
    logic [31:0] first_vq;

    rst = 1'b1; vid_need = 0; frame_sync = 0; cache_wr_req = 0; cache_rd_req = 0;
    cache_waddr = 0; cache_raddr = 0; sys_cmd_ack = 0;
    sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = 0;
    tick(); tick();
    chk("rst_cmd", 32'(sys_cmd), 32'd0);
    chk("rst_addr", 32'(sys_addr), 32'd0);
    chk("rst_idx", 32'(vid_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vq", vq_data, 32'd0);
    rst = 1'b0;
    tick();

    // Strobes in IDLE are ignored.
    sys_rd_data_valid = 1; sys_wr_data_valid = 1;
    #1;
    chk("idle_fill", 32'(cache_fill_en), 32'd0);
    chk("idle_drain", 32'(cache_drain_en), 32'd0);
    tick();
    sys_rd_data_valid = 0; sys_wr_data_valid = 0;
    chk("idle_busy", 32'(busy), 32'd0);

    // Single video burst, ack delayed 3 cycles.
    vid_need = 1;
    tick();
    chk("vid_cmd", 32'(sys_cmd), 32'd2);
    chk("vid_addr", 32'(sys_addr), 32'h3FFA0);
    chk("vid_busy", 32'(busy), 32'd1);
    vid_need = 0;
    tick(); tick();
    chk("vid_cmd_hold", 32'(sys_cmd), 32'd2);
    chk("vid_addr_hold", 32'(sys_addr), 32'h3FFA0);
    sys_cmd_ack = 2'b10;
    tick();
    sys_cmd_ack = 2'b00;
    chk("vid_cmd_clr", 32'(sys_cmd), 32'd0);
    vq_cnt = 0; first_vq = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      sys_rd_data_valid = 1; sys_wr_data_valid = 1; sys_dout = 16'(i);
      #1;
      if (cache_drain_en) vq_cnt += 100;
      tick();
      if (vq_wr) begin
        if (vq_cnt == 0) first_vq = vq_data;
        vq_cnt++;
      end
    end
    sys_rd_data_valid = 0; sys_wr_data_valid = 0;
    chk("vid_vq_cnt", 32'(vq_cnt), 32'd8);
    chk("vid_vq_first", first_vq, 32'h0001_0000);
    chk("vid_vq_last", vq_data, 32'h000F_000E);
    chk("vid_idx1", 32'(vid_idx), 32'd1);
    chk("vid_done", 32'(busy), 32'd0);

    // Write-back beats fill; then fill is issued.
    cache_wr_req = 1; cache_rd_req = 1; cache_waddr = 12'hABC; cache_raddr = 12'h123;
    serve(cmd, addr, cnt, done);
    cache_wr_req = 0;
    chk("cwr_cmd", 32'(cmd), 32'd1);
    chk("cwr_addr", 32'(addr), 32'h2AF00);
    chk("cwr_drain", 32'(cnt), 32'd128);
    chk("cwr_done", 32'(done), 32'd1);
    serve(cmd, addr, cnt, done);
    cache_rd_req = 0;
    chk("crd_cmd", 32'(cmd), 32'd3);
    chk("crd_addr", 32'(addr), 32'h048C0);
    chk("crd_fill", 32'(cnt), 32'd128);
    chk("crd_done", 32'(done), 32'd1);

    // Streak limit: VID x4, CRD, VID.
    vid_need = 1; cache_rd_req = 1; cache_raddr = 12'h321;
    for (int g = 0; g < 6; g++) begin
      serve(cmd, addr, cnt, done);
      if (g == 5) begin vid_need = 0; cache_rd_req = 0; end
      if (g == 4) begin
        chk("streak_crd", 32'(cmd), 32'd3);
        chk("streak_crd_addr", 32'(addr), 32'h0C840);
        chk("streak_crd_done", 32'(done), 32'd1);
      end else begin
        chk($sformatf("streak_vid%0d", g), 32'(cmd), 32'd2);
        chk($sformatf("streak_vq%0d", g), 32'(cnt), 32'd8);
      end
      if (g == 0) chk("vid_addr_idx1", 32'(addr), 32'h3FFA8);
    end
    chk("streak_idx", 32'(vid_idx), 32'd6);

    // Held acknowledge: one acceptance only.
    cache_rd_req = 1; cache_raddr = 12'h0F0;
    wait_cmd(cmd, addr);
    cache_rd_req = 0;
    chk("ackhold_cmd", 32'(cmd), 32'd3);
    burst(cmd, 4, -1, cnt, done);
    chk("ackhold_fill", 32'(cnt), 32'd128);
    chk("ackhold_done", 32'(done), 32'd1);
    chk("ackhold_cmd_end", 32'(sys_cmd), 32'd0);
    chk("ackhold_busy", 32'(busy), 32'd0);

    // Reset at beat 60 of a fill.
    cache_rd_req = 1; cache_raddr = 12'h055;
    wait_cmd(cmd, addr);
    cache_rd_req = 0;
    sys_cmd_ack = 2'b11;
    tick();
    sys_cmd_ack = 2'b00;
    for (int i = 0; i < 60; i++) begin
      sys_rd_data_valid = 1;
      tick();
    end
    #1;
    chk("rst_pre_fill", 32'(cache_fill_en), 32'd1);
    rst = 1;
    #1;
    chk("rstm_cmd", 32'(sys_cmd), 32'd0);
    chk("rstm_addr", 32'(sys_addr), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_fill", 32'(cache_fill_en), 32'd0);
    chk("rstm_idx", 32'(vid_idx), 32'd0);
    chk("rstm_vq", vq_data, 32'd0);
    chk("rstm_done", 32'(cache_done), 32'd0);
    tick();
    rst = 0;
    tick();
    chk("rstm_fill_late", 32'(cache_fill_en), 32'd0);
    sys_rd_data_valid = 0;
    cache_rd_req = 1;
    serve(cmd, addr, cnt, done);
    cache_rd_req = 0;
    chk("rstm_next_cmd", 32'(cmd), 32'd3);
    chk("rstm_next_addr", 32'(addr), 32'h01540);
    chk("rstm_next_fill", 32'(cnt), 32'd128);
    chk("rstm_next_done", 32'(done), 32'd1);

    // Frame resync mid-burst at index 500.
    vid_need = 1;
    for (int i = 0; i < 600 && vid_idx != 12'd500; i++) serve(cmd, addr, cnt, done);
    chk("idx_500", 32'(vid_idx), 32'd500);
    wait_cmd(cmd, addr);
    burst(cmd, 1, 8, cnt, done);
    chk("sync_idx", 32'(vid_idx), 32'd0);
    serve(cmd, addr, cnt, done);
    chk("sync_addr_idx0", 32'(addr), 32'h3FFA0);
    chk("sync_next_idx", 32'(vid_idx), 32'd1);

    // Wrap at VID_LAST.
    for (int i = 0; i < 3200 && vid_idx != 12'd3071; i++) serve(cmd, addr, cnt, done);
    chk("idx_3071", 32'(vid_idx), 32'd3071);
    wait_cmd(cmd, addr);
    chk("wrap_addr", 32'(addr), 32'h39FD8);
    burst(cmd, 1, -1, cnt, done);
    vid_need = 0;
    chk("wrap_idx", 32'(vid_idx), 32'd0);
    chk("wrap_vq", 32'(cnt), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
